// File: rtl/div_issue_stage.sv
// div_issue_stage: operand FIFO, magnitude conversion and issue register feeding the
// free-running divider slice chain, with credit flow control and an N-deep sideband pipe.
// Optional feature macro: DIV_SIGNED_EN (honour in_signed, two's complement operands).
module div_issue_stage #(
    parameter int unsigned N       = 8,
    parameter int unsigned CREDITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [N-1:0]   in_dividend,
    input  logic [N-1:0]   in_divisor,
    output logic [N-1:0]   dividend_o,
    output logic [2*N-2:0] divisor_o,
    output logic [N-1:0]   quotient_o,
    output logic           sb_valid_o,
    output logic           sb_neg_q_o,
    output logic           sb_neg_r_o,
    output logic           sb_dbz_o,
    input  logic           credit_ret,
    output logic           credit_err
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    typedef struct packed {
`ifdef DIV_SIGNED_EN
        logic         sgn;
`endif
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
    } entry_t;

    typedef struct packed {
        logic valid;
        logic neg_q;
        logic neg_r;
        logic dbz;
    } sb_t;

    entry_t [1:0]   fifo_mem;
    entry_t         in_entry;
    entry_t         head;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     fifo_cnt;
    logic           push;
    logic           issue;

    logic [CW-1:0]  credit_cnt;
    logic [CW-1:0]  credit_nxt;
    logic           credit_err_nxt;

    logic           dvd_neg;
    logic           dvs_neg;
    logic           dvs_zero;
    logic [N-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;
    sb_t            sb_stage0;
    sb_t [N:0]      sb_pipe;

`ifndef DIV_SIGNED_EN
    logic unused_signed;
    assign unused_signed = in_signed;
`endif

    assign in_ready   = (fifo_cnt != 2'd2);
    assign push       = in_valid & in_ready;
    assign issue      = (fifo_cnt != 2'd0) && (credit_cnt != '0);
    assign quotient_o = '0;

    // Pack the incoming operand pair into a FIFO entry
    always_comb begin
        in_entry     = '0;
        in_entry.dvd = in_dividend;
        in_entry.dvs = in_divisor;
`ifdef DIV_SIGNED_EN
        in_entry.sgn = in_signed;
`endif
    end

    // FIFO storage; no reset needed, occupancy is tracked by fifo_cnt
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (issue) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, issue})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head operand magnitudes and sideband flags for the issue stage
    always_comb begin
        head = fifo_mem[rd_ptr];
`ifdef DIV_SIGNED_EN
        dvd_neg = head.sgn & head.dvd[N-1];
        dvs_neg = head.sgn & head.dvs[N-1];
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`endif
        dvs_zero = (head.dvs == '0);
        // -2^(N-1) negates to itself, which reads correctly as unsigned 2^(N-1)
        dvd_mag  = dvd_neg ? (~head.dvd + N'(1)) : head.dvd;
        dvs_mag  = dvs_neg ? (~head.dvs + N'(1)) : head.dvs;

        sb_stage0       = '0;
        sb_stage0.valid = issue;
        sb_stage0.neg_q = issue & (dvd_neg ^ dvs_neg) & ~dvs_zero;
        sb_stage0.neg_r = issue & dvd_neg;
        sb_stage0.dbz   = issue & dvs_zero;
    end

    // Issue register: operands on issue, all-zero bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_o <= '0;
            divisor_o  <= '0;
        end else if (issue) begin
            dividend_o <= dvd_mag;
            divisor_o  <= {dvs_mag, {(N-1){1'b0}}};
        end else begin
            dividend_o <= '0;
            divisor_o  <= '0;
        end
    end

    // Sideband pipe: stage 0 sits beside the issue register, stage N lines up with the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_pipe <= '0;
        end else begin
            sb_pipe <= {sb_pipe[N-1:0], sb_stage0};
        end
    end

    assign sb_valid_o = sb_pipe[N].valid;
    assign sb_neg_q_o = sb_pipe[N].neg_q;
    assign sb_neg_r_o = sb_pipe[N].neg_r;
    assign sb_dbz_o   = sb_pipe[N].dbz;

    // Credit update: issue consumes, credit_ret returns; a return at the ceiling is an error
    always_comb begin
        credit_nxt     = credit_cnt;
        credit_err_nxt = credit_err;
        if (issue && !credit_ret) begin
            credit_nxt = credit_cnt - CW'(1);
        end else if (credit_ret && !issue) begin
            if (credit_cnt == CW'(CREDITS)) begin
                credit_err_nxt = 1'b1;
            end else begin
                credit_nxt = credit_cnt + CW'(1);
            end
        end
    end

    // Credit counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            credit_cnt <= credit_nxt;
            credit_err <= credit_err_nxt;
        end
    end

endmodule

// File: tb/tb_div_issue_stage.sv
// Testbench for div_issue_stage: directed vector table, multi-cycle credit and reset
// sequences, and randomized traffic checked every cycle against a behavioural model.
module tb_div_issue_stage;

    localparam int unsigned N       = 8;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned DW      = 2 * N - 1;
`ifdef DIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [N-1:0]  in_dividend = '0;
    logic [N-1:0]  in_divisor = '0;
    logic [N-1:0]  dividend_o;
    logic [DW-1:0] divisor_o;
    logic [N-1:0]  quotient_o;
    logic          sb_valid_o;
    logic          sb_neg_q_o;
    logic          sb_neg_r_o;
    logic          sb_dbz_o;
    logic          credit_ret = 1'b0;
    logic          credit_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int sbv_cnt  = 0;

    div_issue_stage #(.N(N), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .dividend_o (dividend_o),
        .divisor_o  (divisor_o),
        .quotient_o (quotient_o),
        .sb_valid_o (sb_valid_o),
        .sb_neg_q_o (sb_neg_q_o),
        .sb_neg_r_o (sb_neg_r_o),
        .sb_dbz_o   (sb_dbz_o),
        .credit_ret (credit_ret),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        bit           sgn;
    } op_t;

    typedef struct {
        logic [N-1:0]  dvd;
        logic [DW-1:0] dvs;
        bit            v;
        bit            nq;
        bit            nr;
        bit            dbz;
    } exp_t;

    op_t  m_fifo[$];
    exp_t m_pipe[N+1];
    int   m_cred;
    bit   m_err;
    bit   m_acc;
    bit   m_iss;

    function automatic exp_t predict(input op_t op);
        exp_t e;
        int a;
        int b;
        a = (SEN && op.sgn) ? int'($signed(op.dvd)) : int'(op.dvd);
        b = (SEN && op.sgn) ? int'($signed(op.dvs)) : int'(op.dvs);
        e.v   = 1'b1;
        e.dvd = N'(a < 0 ? -a : a);
        e.dvs = DW'((b < 0 ? -b : b) * (1 << (N - 1)));
        e.dbz = (b == 0);
        e.nq  = (b != 0) && ((a < 0) != (b < 0));
        e.nr  = (a < 0);
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.dvd = '0;
        e.dvs = '0;
        e.v   = 1'b0;
        e.nq  = 1'b0;
        e.nr  = 1'b0;
        e.dbz = 1'b0;
        return e;
    endfunction

    // Model state advances on each clock edge; reset clears everything at once
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_cred = CREDITS;
            m_err  = 1'b0;
            for (int i = 0; i <= N; i++) m_pipe[i] = bubble();
        end else begin
            m_acc = in_valid && (m_fifo.size() < 2);
            m_iss = (m_fifo.size() > 0) && (m_cred > 0);
            for (int i = N; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            if (m_iss) m_pipe[0] = predict(m_fifo.pop_front());
            else       m_pipe[0] = bubble();
            if (m_acc) m_fifo.push_back('{in_dividend, in_divisor, in_signed});
            if (m_iss && !credit_ret) m_cred = m_cred - 1;
            else if (credit_ret && !m_iss) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else                   m_cred = m_cred + 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("in_ready",   32'(in_ready),   32'(m_fifo.size() < 2));
            check("dividend_o", 32'(dividend_o), 32'(m_pipe[0].dvd));
            check("divisor_o",  32'(divisor_o),  32'(m_pipe[0].dvs));
            check("quotient_o", 32'(quotient_o), 32'(0));
            check("sb_valid",   32'(sb_valid_o), 32'(m_pipe[N].v));
            check("sb_neg_q",   32'(sb_neg_q_o), 32'(m_pipe[N].nq));
            check("sb_neg_r",   32'(sb_neg_r_o), 32'(m_pipe[N].nr));
            check("sb_dbz",     32'(sb_dbz_o),   32'(m_pipe[N].dbz));
            check("credit_err", 32'(credit_err), 32'(m_err));
        end
    end

    // Running count of results reaching the end of the chain
    always @(posedge clk) begin
        if (rst_n && sb_valid_o === 1'b1) sbv_cnt = sbv_cnt + 1;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [N-1:0]  dvd;
        logic [N-1:0]  dvs;
        bit            sgn;
        logic [N-1:0]  e_dvd;
        logic [DW-1:0] e_dvs;
        bit            e_nq;
        bit            e_nr;
        bit            e_dbz;
        logic [N-1:0]  e_q;
        logic [N-1:0]  e_r;
    } vec_t;

    vec_t vecs[4];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present successive operands each cycle; advance only on acceptance
    task automatic run_offers(input int cycles, input int ret_cycle, input int full_cycle,
                              output int accepts);
        bit rdy;
        accepts = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == full_cycle) check("in_ready_when_full", 32'(in_ready), 32'(0));
            in_valid    = 1'b1;
            in_signed   = 1'b0;
            in_dividend = N'(20 + accepts);
            in_divisor  = N'(3);
            credit_ret  = (c == ret_cycle);
            rdy         = in_ready;
            @(posedge clk);
            if (rdy) accepts++;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        credit_ret = 1'b0;
    endtask

    initial begin
        int acc;
        int base;
        logic [N-1:0] cdvd;
        logic [N-1:0] cdvs;
        logic [N-1:0] cq;
        logic [N-1:0] cr;

        vecs[0] = '{8'd200, 8'd7, 1'b0, 8'd200, DW'(896), 1'b0, 1'b0, 1'b0, 8'd28, 8'd4};
        vecs[1] = '{8'd55, 8'd0, 1'b0, 8'd55, DW'(0), 1'b0, 1'b0, 1'b1, 8'hFF, 8'd55};
        vecs[2] = '{8'h9C, 8'd7, 1'b1, SEN ? 8'd100 : 8'd156, DW'(896), SEN, SEN, 1'b0,
                    SEN ? 8'd14 : 8'd22, 8'd2};
        vecs[3] = '{8'h80, 8'hFF, 1'b1, 8'd128, SEN ? DW'(128) : DW'(32640), 1'b0, SEN, 1'b0,
                    SEN ? 8'd128 : 8'd0, SEN ? 8'd0 : 8'd128};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'(1));
        check("rst_dividend_o", 32'(dividend_o), 32'(0));
        check("rst_divisor_o",  32'(divisor_o),  32'(0));
        check("rst_sb_valid",   32'(sb_valid_o), 32'(0));
        check("rst_credit_err", 32'(credit_err), 32'(0));
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Table: single operation, issue at t+1, sideband at t+1+N, then return its credit
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_dividend = vecs[k].dvd;
            in_divisor  = vecs[k].dvs;
            in_signed   = vecs[k].sgn;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            check("vec_dividend", 32'(dividend_o), 32'(vecs[k].e_dvd));
            check("vec_divisor",  32'(divisor_o),  32'(vecs[k].e_dvs));
            cdvd = dividend_o;
            cdvs = N'(divisor_o >> (N - 1));
            cq   = (cdvs == '0) ? '1 : cdvd / cdvs;
            cr   = (cdvs == '0) ? cdvd : cdvd % cdvs;
            check("vec_chain_q", 32'(cq), 32'(vecs[k].e_q));
            check("vec_chain_r", 32'(cr), 32'(vecs[k].e_r));
            repeat (N) @(negedge clk);
            check("vec_sb_valid", 32'(sb_valid_o), 32'(1));
            check("vec_sb_neg_q", 32'(sb_neg_q_o), 32'(vecs[k].e_nq));
            check("vec_sb_neg_r", 32'(sb_neg_r_o), 32'(vecs[k].e_nr));
            check("vec_sb_dbz",   32'(sb_dbz_o),   32'(vecs[k].e_dbz));
            credit_ret = 1'b1;
            @(negedge clk);
            credit_ret = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Credits exhausted: 4 issues, 2 buffered, then one return lets exactly one more go
        base = sbv_cnt;
        run_offers(8, -1, 6, acc);
        check("exhaust_accepts", 32'(acc), 32'(6));
        repeat (N + 3) @(negedge clk);
        check("exhaust_issues", 32'(sbv_cnt - base), 32'(4));
        check("exhaust_in_ready", 32'(in_ready), 32'(0));
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        check("ret_bubble", 32'(divisor_o), 32'(0));
        @(negedge clk);
        check("ret_issue_dividend", 32'(dividend_o), 32'(24));
        repeat (N + 2) @(negedge clk);
        check("ret_issues", 32'(sbv_cnt - base), 32'(5));
        check("ret_in_ready", 32'(in_ready), 32'(1));

        // Simultaneous issue and credit return at count 2 leaves the count at 2
        do_reset();
        base = sbv_cnt;
        run_offers(8, 3, -1, acc);
        repeat (N + 4) @(negedge clk);
        check("simul_issues", 32'(sbv_cnt - base), 32'(5));

        // Return at the ceiling sets the sticky error
        do_reset();
        check("err_clear", 32'(credit_err), 32'(0));
        @(negedge clk);
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        check("err_set", 32'(credit_err), 32'(1));
        repeat (4) @(negedge clk);
        check("err_sticky", 32'(credit_err), 32'(1));

        // Asynchronous reset with 3 operations in flight
        do_reset();
        check("err_reset", 32'(credit_err), 32'(0));
        base = sbv_cnt;
        run_offers(3, -1, -1, acc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dividend_o", 32'(dividend_o), 32'(0));
        check("arst_divisor_o",  32'(divisor_o),  32'(0));
        check("arst_sb_valid",   32'(sb_valid_o), 32'(0));
        check("arst_in_ready",   32'(in_ready),   32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("arst_no_results", 32'(sbv_cnt - base), 32'(0));
        check("arst_in_ready_after", 32'(in_ready), 32'(1));

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid    = ($urandom_range(0, 99) < 60);
            in_signed   = ($urandom_range(0, 1) == 1);
            in_dividend = N'($urandom);
            in_divisor  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
            credit_ret  = ($urandom_range(0, 99) < 35);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        credit_ret = 1'b0;
        repeat (N + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
